// File: rtl/ad9866_spi_slave.sv
// SPI configuration slave for the AD9866 register map: 16-bit frames, writes and readback.
// Latency: write strobe one clk after the 16th sclk edge is seen; sdo updates one clk after each sclk edge.
// Backpressure: none; the master paces frames with sclk/sen_n, sclk must be slower than clk.
module ad9866_spi_slave #(
  parameter int NREGS = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       sen_n,
  input  logic       sdio,
  output logic       sdo,
  output logic       wr_stb,
  output logic [4:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [5:0] rx_gain,
  output logic       cal_pulse,
  output logic       frame_err
);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t     state;
  logic       sclk_q;
  logic [3:0] bit_cnt;
  logic [14:0] frame;      // bits received so far, newest in bit 0
  logic       armed;       // sen_n has been seen high since reset / last frame start
  logic [7:0] rd_sh;       // remaining readback bits, next one in bit 7
  logic [7:0] regs [NREGS];

  logic       rise;
  logic [4:0] rd_addr;
  logic [7:0] rd_val;
  logic       cmt_rw;
  logic [4:0] cmt_addr;
  logic [7:0] cmt_data;

  // sclk rising edge, only meaningful inside a frame
  assign rise = sclk & ~sclk_q & ~sen_n;

  // On the 8th edge the address LSB is the live sdio bit
  assign rd_addr = {frame[3:0], sdio};

  // On the 16th edge the full frame is the shifted bits plus the live sdio bit
  assign cmt_rw   = frame[14];
  assign cmt_addr = frame[11:7];
  assign cmt_data = {frame[6:0], sdio};

  // Register readback mux; unimplemented addresses read as zero
  always_comb begin
    rd_val = 8'h00;
    for (int i = 0; i < NREGS; i++) begin
      if (rd_addr == i[4:0]) rd_val = regs[i];
    end
  end

  // Frame FSM, shift register, readback serializer and register file
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sclk_q    <= 1'b0;
      bit_cnt   <= 4'd0;
      frame     <= '0;
      armed     <= 1'b0;
      rd_sh     <= 8'h00;
      sdo       <= 1'b0;
      wr_stb    <= 1'b0;
      wr_addr   <= 5'd0;
      wr_data   <= 8'h00;
      rx_gain   <= 6'd0;
      cal_pulse <= 1'b0;
      frame_err <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= 8'h00;
    end else begin
      sclk_q    <= sclk;
      wr_stb    <= 1'b0;
      cal_pulse <= 1'b0;
      frame_err <= 1'b0;
      if (sen_n) armed <= 1'b1;

      case (state)
        IDLE: begin
          sdo <= 1'b0;
          if (!sen_n && armed) begin
            state   <= SHIFT;
            bit_cnt <= 4'd0;
            armed   <= 1'b0;
          end
        end

        SHIFT: begin
          if (sen_n) begin
            // aborted frame: drop everything received so far
            state     <= IDLE;
            frame_err <= 1'b1;
            sdo       <= 1'b0;
          end else if (rise) begin
            frame   <= {frame[13:0], sdio};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              if (frame[6]) begin
                sdo   <= rd_val[7];
                rd_sh <= {rd_val[6:0], 1'b0};
              end else begin
                sdo   <= 1'b0;
                rd_sh <= 8'h00;
              end
            end else if (bit_cnt == 4'd15) begin
              sdo   <= 1'b0;
              state <= HOLD;
              if (!cmt_rw && ({27'd0, cmt_addr} < NREGS)) begin
                for (int i = 0; i < NREGS; i++) begin
                  if (cmt_addr == i[4:0])
                    regs[i] <= (i == 7) ? (cmt_data & 8'hDF) : cmt_data;
                end
                wr_stb    <= 1'b1;
                wr_addr   <= cmt_addr;
                wr_data   <= cmt_data;
                cal_pulse <= (cmt_addr == 5'h07) && cmt_data[5];
                if (cmt_addr == 5'h0A) rx_gain <= cmt_data[5:0];
              end
            end else if (bit_cnt > 4'd7) begin
              sdo   <= rd_sh[7];
              rd_sh <= {rd_sh[6:0], 1'b0};
            end
          end
        end

        HOLD: begin
          sdo <= 1'b0;
          if (sen_n) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ad9866_spi_slave.md
AD9866_SPI_SLAVE -- requirements
Module: ad9866_spi_slave

Interface
REQ-001 SHALL have parameter NREGS, default 20, number of implemented registers (addresses 0x00..NREGS-1).
REQ-002 SHALL have port clk  input  1  sole clock; all inputs synchronous to clk, no synchronizers.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port sclk  input  1  SPI clock from the configuration master.
REQ-005 SHALL have port sen_n  input  1  SPI frame enable, active low.
REQ-006 SHALL have port sdio  input  1  serial data from the master, MSB first.
REQ-007 SHALL have port sdo  output  1  serial read data to the master.
REQ-008 SHALL have port wr_stb  output  1  one-cycle pulse on each committed register write.
REQ-009 SHALL have port wr_addr  output  5  address of the last committed write.
REQ-010 SHALL have port wr_data  output  8  data of the last committed write.
REQ-011 SHALL have port rx_gain  output  6  register 0x0A bits 5:0.
REQ-012 SHALL have port cal_pulse  output  1  one-cycle pulse when DC-offset calibration is requested.
REQ-013 SHALL have port frame_err  output  1  one-cycle pulse on an aborted frame.

Function
REQ-014 SHALL use a 16-bit frame: bit15 R/W (1 = read), bits14:13 ignored, bits12:8 address, bits7:0 data.
REQ-015 SHALL detect an sclk rising edge as sclk = 1 with registered previous sclk = 0, sampling sdio on that clk edge.
REQ-016 SHALL detect an sclk rising edge only while sen_n = 0; edges with sen_n = 1 are ignored.
REQ-017 SHALL implement states IDLE, SHIFT and HOLD.
REQ-018 IDLE -> SHIFT when sen_n = 0; the bit counter SHALL be cleared to 0 on entry.
REQ-019 SHIFT: each detected rising edge SHALL shift sdio into the frame register and increment the bit counter.
REQ-020 SHIFT -> HOLD on the 16th detected rising edge; further sclk edges in HOLD SHALL be ignored.
REQ-021 HOLD -> IDLE when sen_n = 1.
REQ-022 SHIFT -> IDLE when sen_n = 1 with fewer than 16 bits received; frame_err SHALL pulse for exactly one cycle and no register, strobe or sdo side effect SHALL occur.
REQ-023 Write commit (R/W = 0, address < NREGS): on the 16th-edge clk, register[address] SHALL be updated, wr_addr/wr_data loaded and wr_stb asserted the following cycle for one cycle.
REQ-024 Writes to address >= NREGS SHALL be discarded, with no wr_stb.
REQ-025 Read (R/W = 1): on the 8th detected edge (address LSB taken from the live sdio), sdo SHALL be loaded with register[address] bit 7; each subsequent detected edge SHALL advance sdo to the next lower bit, bit 0 last.
REQ-026 sdo SHALL be 0 at all other times, including address-phase bits, write frames, and reads of address >= NREGS.
REQ-027 A write to address 0x07 with data bit 5 = 1 SHALL pulse cal_pulse for one cycle, coincident with wr_stb; bit 5 of register 0x07 SHALL store 0 (self-clearing), and all other bits SHALL be stored as written.
REQ-028 rx_gain SHALL reflect register 0x0A bits 5:0 from the cycle after commit.
REQ-029 A read frame SHALL never modify register contents.
REQ-030 The block SHALL accept back-to-back frames with sen_n high for at least one clk cycle between them.

Reset
REQ-031 Reset SHALL clear all registers to 0x00, set the state to IDLE, and clear the bit counter and frame register.
REQ-032 Reset SHALL drive sdo, wr_stb, cal_pulse and frame_err to 0, and wr_addr, wr_data and rx_gain to 0.
REQ-033 Reset asserted mid-frame SHALL abandon the frame without a write or frame_err; the next frame SHALL start only after sen_n has been observed high.

Verification
REQ-034 Write frame 16'h0A25 -> exactly one wr_stb with wr_addr = 0x0A and wr_data = 0x25; rx_gain = 0x25.
REQ-035 Write frame 16'h0A25, then read frame 16'h8A00 -> sdo carries 0,0,1,0,0,1,0,1 on the last 8 edges; the master captures 0x25.
REQ-036 Write frame 16'h0721 -> cal_pulse for one cycle; read 16'h8700 returns 0x01.
REQ-037 Write frame 16'h1555 (address 0x15) -> no wr_stb; read 16'h9500 returns 0x00.
REQ-038 sen_n deasserted after 10 bits of 16'h0A3F -> frame_err for one cycle; rx_gain unchanged; the next full frame is accepted.
REQ-039 Reset asserted after 12 bits of a write -> no commit, all outputs 0; a subsequent 16'h0B20 frame commits correctly.
